bcd_operand_entry: RTL and testbench

- Keypad-side front end that builds the sign-magnitude BCD operand set consumed by the BCD ALU: A, S_a, B, S_b, OP.
- Accepts one key code per valid/ready handshake and assembles up to 8 BCD digits per operand.
- Presents the completed operation to the ALU stage through a valid/ready issue handshake.
- Operands are held stable until the ALU stage accepts them.

---
 rtl/bcd_operand_entry_pkg.sv | 14 +
 rtl/bcd_operand_entry_digit_shifter.sv | 45 ++++
 rtl/bcd_operand_entry.sv | 140 ++++++++++++++
 tb/tb_bcd_operand_entry.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_operand_entry_pkg.sv
// Shared key codes, FSM states and OP encoding for the BCD operand entry front end.
package bcd_operand_entry_pkg;
  localparam int KEY_PLUS      = 10;
  localparam int KEY_MINUS     = 11;
  localparam int KEY_NEG       = 12;
  localparam int KEY_EQUALS    = 13;
  localparam int KEY_CLEAR     = 14;
  localparam int KEY_BACKSPACE = 15;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, ISSUE, HOLD} state_e;
endpackage

// File: rtl/bcd_operand_entry_digit_shifter.sv
// Packed-BCD operand register with digit count: shift-in, backspace and clear.
module bcd_digit_shifter #(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                push,
  input  logic                pop,
  input  logic [3:0]          digit,
  output logic [4*DIGITS-1:0] val,
  output logic [3:0]          cnt,
  output logic                full
);
  logic [4*DIGITS-1:0] base_val;
  logic [3:0]          base_cnt;

  // clr+push together restarts the operand with the new digit
  assign base_val = clr ? '0 : val;
  assign base_cnt = clr ? '0 : cnt;
  assign full     = (cnt == 4'(DIGITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
      cnt <= '0;
    end else if (push) begin
      if (base_cnt != 4'd0 || digit != 4'd0) begin
        val <= {base_val[4*DIGITS-5:0], digit};
        cnt <= base_cnt + 4'd1;
      end else begin
        val <= base_val;
        cnt <= base_cnt;
      end
    end else if (pop) begin
      if (cnt != 4'd0) begin
        val <= val >> 4;
        cnt <= cnt - 4'd1;
      end
    end else if (clr) begin
      val <= '0;
      cnt <= '0;
    end
  end
endmodule

// File: rtl/bcd_operand_entry.sv
// Keypad front end assembling sign-magnitude BCD operands A/B and OP for the BCD ALU.
// Optional issue timeout enabled by defining BCD_ENTRY_TIMEOUT_EN.
module bcd_operand_entry
  import bcd_operand_entry_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int KEY_W   = 4
`ifdef BCD_ENTRY_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [KEY_W-1:0]    key_code,
  output logic                key_ready,
  output logic [4*DIGITS-1:0] A,
  output logic                S_a,
  output logic [4*DIGITS-1:0] B,
  output logic                S_b,
  output logic                OP,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [3:0]          digit_count,
  output logic                err
);
  state_e      state;
  logic [31:0] kc;
  logic        key_acc;
  logic        k_dig, k_plus, k_minus, k_neg, k_eq, k_clr, k_bs, k_bad;
  logic        a_push, a_pop, a_clr, a_full;
  logic        b_push, b_pop, b_clr, b_full;
  logic [3:0]  a_cnt, b_cnt;
  logic        rej;

  assign kc      = 32'(key_code);
  assign key_acc = key_valid & key_ready;
  assign k_dig   = key_acc & (kc <= 32'd9);
  assign k_plus  = key_acc & (kc == 32'(KEY_PLUS));
  assign k_minus = key_acc & (kc == 32'(KEY_MINUS));
  assign k_neg   = key_acc & (kc == 32'(KEY_NEG));
  assign k_eq    = key_acc & (kc == 32'(KEY_EQUALS));
  assign k_clr   = key_acc & (kc == 32'(KEY_CLEAR));
  assign k_bs    = key_acc & (kc == 32'(KEY_BACKSPACE));
  assign k_bad   = key_acc & (kc > 32'(KEY_BACKSPACE));

  // a digit in HOLD starts a fresh operation with that digit as A
  assign a_clr  = k_clr | (state == HOLD & k_dig);
  assign b_clr  = k_clr | (state == HOLD & k_dig) | (state == ENTER_A & (k_plus | k_minus));
  assign a_push = k_dig & ((state == ENTER_A & ~a_full) | state == HOLD);
  assign b_push = k_dig & state == ENTER_B & ~b_full;
  assign a_pop  = k_bs & state == ENTER_A;
  assign b_pop  = k_bs & state == ENTER_B;

  assign rej = (k_dig & ((state == ENTER_A & a_full) | (state == ENTER_B & b_full)))
             | (k_eq & state == ENTER_A)
             | ((k_plus | k_minus) & state == ENTER_B & b_cnt != 4'd0)
             | (key_acc & state == HOLD & ~(k_dig | k_clr))
             | k_bad;

  bcd_digit_shifter #(.DIGITS(DIGITS)) u_a (
    .clk(clk), .rst(rst), .clr(a_clr), .push(a_push), .pop(a_pop),
    .digit(key_code[3:0]), .val(A), .cnt(a_cnt), .full(a_full)
  );

  bcd_digit_shifter #(.DIGITS(DIGITS)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr), .push(b_push), .pop(b_pop),
    .digit(key_code[3:0]), .val(B), .cnt(b_cnt), .full(b_full)
  );

`ifdef BCD_ENTRY_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tcnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ENTER_A;
      S_a   <= 1'b0;
      S_b   <= 1'b0;
      OP    <= OP_ADD;
      err   <= 1'b0;
`ifdef BCD_ENTRY_TIMEOUT_EN
      tcnt  <= '0;
`endif
    end else begin
      err <= rej;
      if (k_clr) begin
        state <= ENTER_A;
        S_a   <= 1'b0;
        S_b   <= 1'b0;
        OP    <= OP_ADD;
      end else begin
        case (state)
          ENTER_A: begin
            if (k_neg) S_a <= ~S_a;
            else if (k_plus | k_minus) begin
              OP    <= k_minus ? OP_SUB : OP_ADD;
              S_b   <= 1'b0;
              state <= ENTER_B;
            end
          end
          ENTER_B: begin
            if (k_neg) S_b <= ~S_b;
            else if ((k_plus | k_minus) && b_cnt == 4'd0) OP <= k_minus ? OP_SUB : OP_ADD;
            else if (k_eq) begin
              state <= ISSUE;
`ifdef BCD_ENTRY_TIMEOUT_EN
              tcnt  <= '0;
`endif
            end
          end
          ISSUE: begin
            if (op_ready) state <= HOLD;
`ifdef BCD_ENTRY_TIMEOUT_EN
            else if (tcnt == TCW'(TIMEOUT - 1)) begin
              state <= ENTER_B;
              err   <= 1'b1;
            end else tcnt <= tcnt + TCW'(1);
`endif
          end
          HOLD: begin
            if (k_dig) begin
              state <= ENTER_A;
              S_a   <= 1'b0;
              S_b   <= 1'b0;
              OP    <= OP_ADD;
            end
          end
          default: state <= ENTER_A;
        endcase
      end
    end
  end

  assign key_ready   = (state != ISSUE);
  assign op_valid    = (state == ISSUE);
  assign digit_count = (state == ENTER_A) ? a_cnt : b_cnt;
endmodule

// File: tb/tb_bcd_operand_entry.sv
// Self-checking bench for bcd_operand_entry: directed scenarios plus random keys vs a decimal model.
module tb_bcd_operand_entry;
  localparam int MA = 0, MB = 1, MI = 2, MH = 3;
  localparam int TOUT = 8;
`ifdef BCD_ENTRY_TIMEOUT_EN
  localparam int STALL = 4;
`else
  localparam int STALL = 50;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        key_ready;
  logic [31:0] A, B;
  logic        S_a, S_b, OP, op_valid, err;
  logic        op_ready = 1'b0;
  logic [3:0]  digit_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_operand_entry #(
    .DIGITS(8), .KEY_W(4)
`ifdef BCD_ENTRY_TIMEOUT_EN
    , .TIMEOUT(TOUT)
`endif
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .A(A), .S_a(S_a), .B(B), .S_b(S_b), .OP(OP),
    .op_valid(op_valid), .op_ready(op_ready), .digit_count(digit_count), .err(err)
  );

  // Reference model: operands held as decimal integers plus digit counts
  int     m_st = MA;
  longint ma = 0, mb = 0;
  int     ca = 0, cb = 0, m_tc = 0;
  bit     sa = 0, sb = 0, mop = 0, m_err = 0;
  int     kin;
  assign kin = int'(key_code);

  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r;
    longint t;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m_err <= 1'b0;
    if (rst) begin
      m_st <= MA; ma <= 0; mb <= 0; ca <= 0; cb <= 0; sa <= 0; sb <= 0; mop <= 0;
    end else if (m_st == MI) begin
      if (op_ready) m_st <= MH;
`ifdef BCD_ENTRY_TIMEOUT_EN
      else if (m_tc == TOUT - 1) begin m_st <= MB; m_err <= 1'b1; end
      m_tc <= m_tc + 1;
`endif
    end else if (key_valid) begin
      if (kin == 14) begin
        m_st <= MA; ma <= 0; mb <= 0; ca <= 0; cb <= 0; sa <= 0; sb <= 0; mop <= 0;
      end else if (kin <= 9) begin
        if (m_st == MH) begin
          ma <= kin; ca <= (kin != 0) ? 1 : 0; mb <= 0; cb <= 0;
          sa <= 0; sb <= 0; mop <= 0; m_st <= MA;
        end else if (m_st == MA) begin
          if (ca == 8) m_err <= 1'b1;
          else if (!(ca == 0 && kin == 0)) begin ma <= ma * 10 + kin; ca <= ca + 1; end
        end else begin
          if (cb == 8) m_err <= 1'b1;
          else if (!(cb == 0 && kin == 0)) begin mb <= mb * 10 + kin; cb <= cb + 1; end
        end
      end else if (m_st == MH) m_err <= 1'b1;
      else if (kin == 15) begin
        if (m_st == MA && ca > 0) begin ma <= ma / 10; ca <= ca - 1; end
        if (m_st == MB && cb > 0) begin mb <= mb / 10; cb <= cb - 1; end
      end else if (kin == 12) begin
        if (m_st == MA) sa <= ~sa; else sb <= ~sb;
      end else if (kin == 13) begin
        if (m_st == MA) m_err <= 1'b1;
        else begin
          m_st <= MI;
          m_tc <= 0;
        end
      end else begin
        if (m_st == MA) begin mop <= (kin == 11); mb <= 0; cb <= 0; sb <= 0; m_st <= MB; end
        else if (cb == 0) mop <= (kin == 11);
        else m_err <= 1'b1;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the key's clock edge.
  task automatic press(input int k, input bit keep = 1'b0);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(posedge clk);
    @(negedge clk);
    if (!keep) key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; op_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({A, B} !== 64'h0) begin n_fail++; $display("FAIL reset_ab A=%h B=%h expected 0", A, B); end
    n_chk++;
    if ({S_a, S_b, OP, op_valid, err, key_ready, digit_count} !== 10'b0000010000) begin
      n_fail++;
      $display("FAIL reset_flags got %b expected 0000010000", {S_a, S_b, OP, op_valid, err, key_ready, digit_count});
    end
  endtask

  task automatic test_basic_add();
    op_ready = 1'b1;
    press(1); press(2); press(3); press(10); press(4); press(5); press(13);
    n_chk++;
    if ({A, B} !== {32'h123, 32'h45}) begin n_fail++; $display("FAIL add_ops A=%h B=%h expected 123/45", A, B); end
    n_chk++;
    if ({op_valid, key_ready, OP, S_a, S_b} !== 5'b10000) begin
      n_fail++; $display("FAIL add_issue got %b expected 10000", {op_valid, key_ready, OP, S_a, S_b});
    end
    @(negedge clk);
    op_ready = 1'b0;
    n_chk++;
    if ({op_valid, key_ready, A} !== {2'b01, 32'h123}) begin
      n_fail++; $display("FAIL add_hold op_valid=%b key_ready=%b A=%h expected 0 1 123", op_valid, key_ready, A);
    end
  endtask

  task automatic test_hold_digit();
    press(5);
    n_chk++;
    if ({A, B, OP, err, digit_count} !== {32'h5, 32'h0, 2'b00, 4'd1}) begin
      n_fail++; $display("FAIL hold_digit A=%h B=%h OP=%b err=%b cnt=%0d expected 5 0 0 0 1", A, B, OP, err, digit_count);
    end
  endtask

  task automatic test_signs_stall();
    bit stable = 1'b1;
    press(14);
    press(0); press(0); press(7); press(12); press(11); press(9); press(12); press(13);
    n_chk++;
    if ({A, S_a, OP, B, S_b, op_valid} !== {32'h7, 2'b11, 32'h9, 2'b11}) begin
      n_fail++; $display("FAIL signs A=%h S_a=%b OP=%b B=%h S_b=%b v=%b expected 7 1 1 9 1 1", A, S_a, OP, B, S_b, op_valid);
    end
    for (int i = 0; i < STALL; i++) begin
      @(negedge clk);
      if ({A, B, S_a, S_b, OP, op_valid, key_ready} !== {32'h7, 32'h9, 5'b11110}) stable = 1'b0;
    end
    n_chk++;
    if (!stable) begin n_fail++; $display("FAIL issue_stall outputs moved got 0 expected 1 (stable)"); end
    press(3);
    n_chk++;
    if ({A, err, op_valid} !== {32'h7, 2'b01}) begin
      n_fail++; $display("FAIL issue_key_ignored A=%h err=%b v=%b expected 7 0 1", A, err, op_valid);
    end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    n_chk++;
    if ({op_valid, key_ready, A, S_a} !== {2'b01, 32'h7, 1'b1}) begin
      n_fail++; $display("FAIL signs_hold v=%b rdy=%b A=%h S_a=%b expected 0 1 7 1", op_valid, key_ready, A, S_a);
    end
    press(3);
    n_chk++;
    if ({A, B, S_a, S_b, OP} !== {32'h3, 32'h0, 3'b000}) begin
      n_fail++; $display("FAIL hold_restart A=%h B=%h S_a=%b S_b=%b OP=%b expected 3 0 0 0 0", A, B, S_a, S_b, OP);
    end
  endtask

  task automatic test_reset_in_issue();
    press(14); press(1); press(10); press(2); press(12); press(13);
    n_chk++;
    if (op_valid !== 1'b1) begin n_fail++; $display("FAIL rst_issue_pre op_valid=%b expected 1", op_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({op_valid, key_ready, A, B, S_b, err} !== {2'b01, 64'h0, 2'b00}) begin
      n_fail++; $display("FAIL rst_issue v=%b rdy=%b A=%h B=%h S_b=%b err=%b expected 0 1 0 0 0 0", op_valid, key_ready, A, B, S_b, err);
    end
  endtask

  task automatic test_overflow();
    press(14);
    for (int d = 1; d <= 8; d++) press(d);
    press(9);
    n_chk++;
    if ({A, digit_count, err} !== {32'h12345678, 4'd8, 1'b1}) begin
      n_fail++; $display("FAIL overflow A=%h cnt=%0d err=%b expected 12345678 8 1", A, digit_count, err);
    end
    @(negedge clk);
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse err=%b expected 0", err); end
    press(15);
    n_chk++;
    if ({A, digit_count} !== {32'h01234567, 4'd7}) begin
      n_fail++; $display("FAIL backspace A=%h cnt=%0d expected 01234567 7", A, digit_count);
    end
  endtask

  task automatic test_ops();
    press(14);
    press(13);
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL eq_in_a err=%b expected 1", err); end
    press(4);
    n_chk++;
    if ({A, digit_count} !== {32'h4, 4'd1}) begin n_fail++; $display("FAIL eq_no_move A=%h cnt=%0d expected 4 1", A, digit_count); end
    press(10); press(11);
    n_chk++;
    if ({OP, err, digit_count} !== {2'b10, 4'd0}) begin
      n_fail++; $display("FAIL op_overwrite OP=%b err=%b cnt=%0d expected 1 0 0", OP, err, digit_count);
    end
    press(15);
    n_chk++;
    if ({err, digit_count} !== {1'b0, 4'd0}) begin n_fail++; $display("FAIL bs_empty err=%b cnt=%0d expected 0 0", err, digit_count); end
    press(6); press(10);
    n_chk++;
    if ({OP, err, B} !== {2'b11, 32'h6}) begin n_fail++; $display("FAIL op_after_digit OP=%b err=%b B=%h expected 1 1 6", OP, err, B); end
  endtask

  task automatic test_back_to_back();
    press(14);
    press(1, 1'b1); press(2, 1'b1); press(3, 1'b1); press(12);
    n_chk++;
    if ({A, S_a, digit_count} !== {32'h123, 1'b1, 4'd3}) begin
      n_fail++; $display("FAIL back_to_back A=%h S_a=%b cnt=%0d expected 123 1 3", A, S_a, digit_count);
    end
  endtask

`ifdef BCD_ENTRY_TIMEOUT_EN
  task automatic test_timeout();
    int n = 1;
    op_ready = 1'b0;
    press(14); press(1); press(10); press(2); press(13);
    for (int i = 0; i < 20 && op_valid; i++) begin
      @(negedge clk);
      if (op_valid) n++;
    end
    n_chk++;
    if (n !== TOUT) begin n_fail++; $display("FAIL timeout_len got %0d cycles expected %0d", n, TOUT); end
    n_chk++;
    if ({err, key_ready, A, B, digit_count} !== {2'b11, 32'h1, 32'h2, 4'd1}) begin
      n_fail++; $display("FAIL timeout_state err=%b rdy=%b A=%h B=%h cnt=%0d expected 1 1 1 2 1", err, key_ready, A, B, digit_count);
    end
    press(14);
  endtask
`endif

  task automatic test_random();
    logic [9:0] exp_f;
    for (int it = 0; it < 400; it++) begin
      op_ready = ($urandom_range(0, 2) == 0);
      if (m_st == MI) @(negedge clk);
      else if ($urandom_range(0, 9) < 6) press($urandom_range(0, 9));
      else press($urandom_range(10, 15));
      exp_f = {sa, sb, mop, m_err, (m_st == MI), (m_st != MI), 4'((m_st == MA) ? ca : cb)};
      n_chk++;
      if (A !== to_bcd(ma)) begin n_fail++; $display("FAIL rand_A it=%0d A=%h expected %h", it, A, to_bcd(ma)); end
      n_chk++;
      if (B !== to_bcd(mb)) begin n_fail++; $display("FAIL rand_B it=%0d B=%h expected %h", it, B, to_bcd(mb)); end
      n_chk++;
      if ({S_a, S_b, OP, err, op_valid, key_ready, digit_count} !== exp_f) begin
        n_fail++;
        $display("FAIL rand_flags it=%0d got %b expected %b", it, {S_a, S_b, OP, err, op_valid, key_ready, digit_count}, exp_f);
      end
    end
    op_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_hold_digit();
    test_signs_stall();
    test_reset_in_issue();
    test_overflow();
    test_ops();
    test_back_to_back();
`ifdef BCD_ENTRY_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, expected completion before 500000");
    $fatal(1);
  end
endmodule
